// File: rtl/pipe_stage_skid_if.sv
// rtl/pipe_stage_skid_if.sv - valid/ready stream bundle (ctrl + data) for pipeline stage boundaries.
interface pipe_stage_skid_if #(
    parameter int CTRL_W = 11,
    parameter int DATA_W = 143
);
    logic              valid;
    logic              ready;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;

    modport master (output valid, output ctrl, output data, input ready);
    modport slave  (input valid, input ctrl, input data, output ready);
endinterface

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - pipeline stage register with two-entry skid buffer and flush-to-bubble.
// Optional statistics counters (bubble_cnt, stall_cnt) are built only with PIPE_STAGE_STATS_EN.
module pipe_stage_skid #(
    parameter int CTRL_W = 11,
    parameter int DATA_W = 143
`ifdef PIPE_STAGE_STATS_EN
    ,
    parameter int CNT_W  = 32
`endif
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    pipe_stage_skid_if.slave    i_in,
    pipe_stage_skid_if.master   o_out
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [CNT_W-1:0]    bubble_cnt,
    output logic [CNT_W-1:0]    stall_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [DATA_W-1:0] r_skid_data;

    logic w_in_ready;
    logic w_out_valid;
    logic w_accept;
    logic w_pop;
    logic w_load_main_in;
    logic w_load_main_skid;
    logic w_load_skid;

    // Both handshake outputs come straight from the state flops, which is what
    // keeps out_ready/flush from reaching in_ready combinationally.
    assign w_in_ready  = (r_state != ST_SKID);
    assign w_out_valid = (r_state != ST_EMPTY);
    assign w_accept    = i_in.valid & w_in_ready;
    assign w_pop       = w_out_valid & o_out.ready;

    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt    = ST_FULL;
                        w_load_main_in = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (w_pop && w_accept) begin
                        w_load_main_in = 1'b1;
                    end else if (w_pop) begin
                        w_state_nxt = ST_EMPTY;
                    end else if (w_accept) begin
                        w_state_nxt = ST_SKID;
                        w_load_skid = 1'b1;
                    end
                end
                ST_SKID: begin
                    if (w_pop) begin
                        w_state_nxt      = ST_FULL;
                        w_load_main_skid = 1'b1;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Flush turns held beats into NOPs but leaves payloads in place.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_main_ctrl <= '0;
            r_main_data <= '0;
            r_skid_ctrl <= '0;
            r_skid_data <= '0;
        end else if (flush) begin
            r_main_ctrl <= '0;
            r_skid_ctrl <= '0;
        end else begin
            if (w_load_main_in) begin
                r_main_ctrl <= i_in.ctrl;
                r_main_data <= i_in.data;
            end else if (w_load_main_skid) begin
                r_main_ctrl <= r_skid_ctrl;
                r_main_data <= r_skid_data;
            end
            if (w_load_skid) begin
                r_skid_ctrl <= i_in.ctrl;
                r_skid_data <= i_in.data;
            end
        end
    end

    assign i_in.ready  = w_in_ready;
    assign o_out.valid = w_out_valid;
    assign o_out.ctrl  = w_out_valid ? r_main_ctrl : '0;
    assign o_out.data  = r_main_data;

`ifdef PIPE_STAGE_STATS_EN
    logic [CNT_W-1:0] r_bubble_cnt;
    logic [CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bubble_cnt <= '0;
            r_stall_cnt  <= '0;
        end else begin
            if (!w_out_valid && (r_bubble_cnt != '1)) begin
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
            end
            if (w_out_valid && !o_out.ready && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign bubble_cnt = r_bubble_cnt;
    assign stall_cnt  = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - vector table, corner sequences and random run against a queue model.
module tb_pipe_stage_skid;
    localparam int CTRL_W = 11;
    localparam int DATA_W = 143;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    pipe_stage_skid_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) up ();
    pipe_stage_skid_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) dn ();

`ifdef PIPE_STAGE_STATS_EN
    logic [31:0] bubble_cnt;
    logic [31:0] stall_cnt;
    logic [3:0]  sat_bubble;
    logic [3:0]  sat_stall;
    pipe_stage_skid_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) sup ();
    pipe_stage_skid_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) sdn ();

    pipe_stage_skid #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .flush(flush), .i_in(up), .o_out(dn),
        .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
    );
    pipe_stage_skid #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .flush(1'b0), .i_in(sup), .o_out(sdn),
        .bubble_cnt(sat_bubble), .stall_cnt(sat_stall)
    );
    initial begin
        sup.valid = 1'b0;
        sup.ctrl  = '0;
        sup.data  = '0;
        sdn.ready = 1'b0;
    end
`else
    pipe_stage_skid #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset), .flush(flush), .i_in(up), .o_out(dn)
    );
`endif

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
    } beat_t;

    beat_t             mq[$];
    logic [DATA_W-1:0] m_data;
    logic [31:0]       m_bub;
    logic [31:0]       m_stall;

    typedef struct packed {
        logic              iv;
        logic [CTRL_W-1:0] ctrl;
        logic              ordy;
        logic              e_ov;
        logic              e_ir;
        logic [CTRL_W-1:0] e_ctrl;
    } vec_t;

    vec_t vt [16];

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] rand_data();
        logic [159:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return t[DATA_W-1:0];
    endfunction

    task automatic drive(input logic iv, input logic [CTRL_W-1:0] c, input logic ordy, input logic fl);
        up.valid = iv;
        up.ctrl  = c;
        up.data  = rand_data();
        dn.ready = ordy;
        flush    = fl;
    endtask

    task automatic model_reset();
        mq.delete();
        m_data  = '0;
        m_bub   = '0;
        m_stall = '0;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".out_valid"}, dn.valid, mq.size() > 0);
        chk({tag, ".in_ready"}, up.ready, mq.size() < 2);
        chk({tag, ".out_ctrl"}, dn.ctrl, (mq.size() > 0) ? mq[0].ctrl : '0);
        chk({tag, ".out_data"}, dn.data, m_data);
`ifdef PIPE_STAGE_STATS_EN
        chk({tag, ".bubble_cnt"}, bubble_cnt, m_bub);
        chk({tag, ".stall_cnt"}, stall_cnt, m_stall);
`endif
    endtask

    // One clock edge: the model decides from pre-edge inputs, then outputs are compared 1ns after the edge.
    task automatic cycle(input string tag);
        bit    acc;
        bit    pop;
        bit    fl;
        beat_t b;
        acc    = up.valid && (mq.size() < 2);
        pop    = (mq.size() > 0) && dn.ready;
        fl     = flush;
        b.ctrl = up.ctrl;
        b.data = up.data;
        if (mq.size() == 0 && m_bub != '1) m_bub++;
        if (mq.size() > 0 && !dn.ready && m_stall != '1) m_stall++;
        @(posedge clk);
        #1;
        if (fl) begin
            mq.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            if (acc) mq.push_back(b);
        end
        if (mq.size() > 0) m_data = mq[0].data;
        check_model(tag);
    endtask

    logic [DATA_W-1:0] d_a;

    initial begin
        for (int i = 0; i < 8; i++) vt[i] = '{1'b1, CTRL_W'(i + 1), 1'b1, 1'b1, 1'b1, CTRL_W'(i + 1)};
        vt[8]  = '{1'b0, 11'h000, 1'b1, 1'b0, 1'b1, 11'h000};
        vt[9]  = '{1'b1, 11'h00A, 1'b1, 1'b1, 1'b1, 11'h00A};
        vt[10] = '{1'b1, 11'h00B, 1'b0, 1'b1, 1'b0, 11'h00A};
        vt[11] = '{1'b1, 11'h00C, 1'b0, 1'b1, 1'b0, 11'h00A};
        vt[12] = '{1'b1, 11'h00C, 1'b0, 1'b1, 1'b0, 11'h00A};
        vt[13] = '{1'b1, 11'h00C, 1'b1, 1'b1, 1'b1, 11'h00B};
        vt[14] = '{1'b1, 11'h00C, 1'b1, 1'b1, 1'b1, 11'h00C};
        vt[15] = '{1'b0, 11'h000, 1'b1, 1'b0, 1'b1, 11'h000};

        drive(1'b0, '0, 1'b0, 1'b0);
        model_reset();
        #1 reset = 1'b1;
        #1;
        chk("reset.out_valid", dn.valid, 1'b0);
        chk("reset.out_ctrl", dn.ctrl, 0);
        chk("reset.out_data", dn.data, 0);
        chk("reset.in_ready", up.ready, 1'b1);
        @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < 5; i++) cycle("idle");
`ifdef PIPE_STAGE_STATS_EN
        chk("bubble_after_5", bubble_cnt, 5);
        for (int i = 0; i < 15; i++) cycle("idle");
        chk("bubble_sat_cnt4", sat_bubble, 15);
        chk("bubble_after_20", bubble_cnt, 20);
`endif

        for (int i = 0; i < 16; i++) begin
            drive(vt[i].iv, vt[i].ctrl, vt[i].ordy, 1'b0);
            cycle("vec");
            chk($sformatf("vec%0d.out_valid", i), dn.valid, vt[i].e_ov);
            chk($sformatf("vec%0d.in_ready", i), up.ready, vt[i].e_ir);
            chk($sformatf("vec%0d.out_ctrl", i), dn.ctrl, vt[i].e_ctrl);
        end
`ifdef PIPE_STAGE_STATS_EN
        chk("stall_cnt_3", stall_cnt, 3);
`endif

        drive(1'b1, 11'h011, 1'b1, 1'b0);
        d_a = up.data;
        cycle("fl_fill_a");
        drive(1'b1, 11'h012, 1'b0, 1'b0);
        cycle("fl_fill_b");
        chk("fl.skid_in_ready", up.ready, 1'b0);
        drive(1'b1, 11'h013, 1'b0, 1'b1);
        cycle("fl_flush");
        chk("fl.out_valid", dn.valid, 1'b0);
        chk("fl.out_ctrl", dn.ctrl, 0);
        chk("fl.in_ready", up.ready, 1'b1);
        chk("fl.out_data_kept", dn.data, d_a);
        drive(1'b0, '0, 1'b1, 1'b0);
        cycle("fl_after");
        chk("fl.beat_dropped", dn.valid, 1'b0);

        drive(1'b1, 11'h021, 1'b1, 1'b0);
        cycle("rs_fill_a");
        drive(1'b1, 11'h022, 1'b0, 1'b0);
        cycle("rs_fill_b");
        chk("rs.skid_in_ready", up.ready, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk("rs.async_out_valid", dn.valid, 1'b0);
        chk("rs.async_in_ready", up.ready, 1'b1);
        chk("rs.async_out_ctrl", dn.ctrl, 0);
        chk("rs.async_out_data", dn.data, 0);
        model_reset();
        #2 reset = 1'b0;
        drive(1'b1, 11'h023, 1'b1, 1'b0);
        cycle("rs_first");
        chk("rs.first_ctrl", dn.ctrl, 11'h023);
        drive(1'b0, '0, 1'b1, 1'b0);
        cycle("rs_alone");
        chk("rs.alone_valid", dn.valid, 1'b0);

        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom), CTRL_W'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
            cycle("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
